// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Multi-cycle KGP-RISC sequencer. Owns PC and IR, steps each
//             instruction through fetch/decode/execute/memory/writeback.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic        valid_jump,
    input  logic [31:0] rs_value,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_en,
    output logic        reg_we,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_BRANCH = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_BREG  = 6'b001011;
    localparam logic [5:0] OP_BL    = 6'b001101;
    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b010001;

    state_t      cur;
    logic        taken;
    logic [31:0] tgt_reg;

    logic [5:0]  opcode;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] branch_pc;

    assign opcode     = ir[31:26];
    assign is_branch  = (opcode[5:3] == 3'b001);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{4{ir[25]}}, ir[25:0], 2'b00};

    always_comb begin
        branch_pc = pc_plus4;
        if (taken) begin
            branch_pc = (opcode == OP_BREG) ? tgt_reg : (pc_plus4 + branch_off);
        end
    end

    // Strobes decode the state register directly so reset kills them at once.
    assign state     = cur;
    assign imem_req  = (cur == S_FETCH);
    assign alu_en    = (cur == S_EXEC);
    assign dmem_req  = (cur == S_MEM);
    assign dmem_we   = (cur == S_MEM) && is_store;
    assign reg_we    = (cur == S_WB);
    assign link_we   = (cur == S_BRANCH) && (opcode == OP_BL);
    assign halted    = (cur == S_HALT);
    assign link_data = pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            taken   <= 1'b0;
            tgt_reg <= 32'd0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (start) cur <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir  <= imem_rdata;
                        cur <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cur <= (opcode == HALT_OP) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    taken   <= valid_jump;
                    tgt_reg <= rs_value;
                    if (is_branch)                cur <= S_BRANCH;
                    else if (is_load || is_store) cur <= S_MEM;
                    else                          cur <= S_WB;
                end
                S_BRANCH: begin
                    pc  <= branch_pc;
                    cur <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_load) begin
                            cur <= S_WB;
                        end else begin
                            pc  <= pc_plus4;
                            cur <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc  <= pc_plus4;
                    cur <= S_FETCH;
                end
                S_HALT: begin
                    cur <= S_HALT;
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed scoreboard bench for pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_ack;
    logic        valid_jump;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        alu_en;
    logic        reg_we;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    logic [2:0]  state;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_ack   (dmem_ack),
        .valid_jump (valid_jump),
        .rs_value   (rs_value),
        .pc         (pc),
        .ir         (ir),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .alu_en     (alu_en),
        .reg_we     (reg_we),
        .link_we    (link_we),
        .link_data  (link_data),
        .halted     (halted),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          cycles;
        int          alu;
        int          regwe;
        int          link;
        logic [31:0] link_data;
        int          dreq;
        int          dwe;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] I_ALU  = 32'h0000_0000;
    localparam logic [31:0] I_BREG = 32'h2C00_0000;
    localparam logic [31:0] I_B_M2 = 32'h33FF_FFFE;
    localparam logic [31:0] I_BL   = 32'h3400_0010;
    localparam logic [31:0] I_LD   = 32'h4000_0000;
    localparam logic [31:0] I_ST   = 32'h4400_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input int cyc, input int a, input int r,
                                input int l, input logic [31:0] ld, input int dr, input int dw);
        exp_t e;
        e.pc = p; e.cycles = cyc; e.alu = a; e.regwe = r;
        e.link = l; e.link_data = ld; e.dreq = dr; e.dwe = dw;
        return e;
    endfunction

    // Monitor: an instruction retires when the next FETCH begins.
    logic [2:0]  prev_state = 3'd0;
    bit          in_flight  = 1'b0;
    int          cyc, n_alu, n_reg, n_link, n_dreq, n_dwe;
    logic [31:0] seen_ld;

    task automatic retire();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire: got pc %h expected no instruction", pc);
        end else begin
            e = q.pop_front();
            chk("pc_after",  pc,                 e.pc);
            chk("cycles",    32'(cyc),           32'(e.cycles));
            chk("alu_en_n",  32'(n_alu),         32'(e.alu));
            chk("reg_we_n",  32'(n_reg),         32'(e.regwe));
            chk("link_we_n", 32'(n_link),        32'(e.link));
            chk("dmem_req_n",32'(n_dreq),        32'(e.dreq));
            chk("dmem_we_n", 32'(n_dwe),         32'(e.dwe));
            if (e.link != 0) chk("link_data", seen_ld, e.link_data);
        end
    endtask

    always @(negedge clk) begin
        if (rst || state == 3'd0) begin
            in_flight = 1'b0;
        end else begin
            if (state == 3'd1 && prev_state != 3'd1) begin
                if (in_flight) retire();
                in_flight = 1'b1;
                cyc = 0; n_alu = 0; n_reg = 0; n_link = 0; n_dreq = 0; n_dwe = 0;
                seen_ld = 32'd0;
            end
            if (in_flight) begin
                cyc++;
                n_alu  += int'(alu_en);
                n_reg  += int'(reg_we);
                n_link += int'(link_we);
                n_dreq += int'(dmem_req);
                n_dwe  += int'(dmem_we);
                if (link_we) seen_ld = link_data;
            end
        end
        prev_state = state;
    end

    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n = 0;
        while (state !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (state === s);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_state: got %0d expected %0d", state, s);
        end
    endtask

    task automatic run(input logic [31:0] instr, input logic vj, input logic [31:0] rsv,
                       input int iw, input int dw, input bit is_mem, input exp_t e);
        bit ok;
        q.push_back(e);
        wait_state(3'd1, ok);
        if (!ok) return;
        valid_jump = vj;
        rs_value   = rsv;
        imem_rdata = instr;
        repeat (iw) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        if (is_mem) begin
            wait_state(3'd5, ok);
            if (!ok) return;
            repeat (dw) @(negedge clk);
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        dmem_ack = 1'b0; valid_jump = 1'b0; rs_value = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_pc",        pc,             32'd0);
        chk("rst_ir",        ir,             32'd0);
        chk("rst_imem_req",  32'(imem_req),  32'd0);
        chk("rst_link_data", link_data,      32'd4);
        rst   = 1'b0;
        start = 1'b1;

        run(I_ALU,  1'b1, 32'd0,         0, 0, 1'b0, mk(32'h4,         4, 1, 1, 0, 0,          0, 0));
        run(I_BREG, 1'b1, 32'h100,       0, 0, 1'b0, mk(32'h100,       4, 1, 0, 0, 0,          0, 0));
        run(I_B_M2, 1'b1, 32'd0,         0, 0, 1'b0, mk(32'h0FC,       4, 1, 0, 0, 0,          0, 0));
        run(I_BREG, 1'b1, 32'h100,       0, 0, 1'b0, mk(32'h100,       4, 1, 0, 0, 0,          0, 0));
        run(I_B_M2, 1'b0, 32'd0,         0, 0, 1'b0, mk(32'h104,       4, 1, 0, 0, 0,          0, 0));
        run(I_BREG, 1'b1, 32'h200,       0, 0, 1'b0, mk(32'h200,       4, 1, 0, 0, 0,          0, 0));
        run(I_BL,   1'b1, 32'd0,         0, 0, 1'b0, mk(32'h244,       4, 1, 0, 1, 32'h204,    0, 0));
        run(I_BL,   1'b0, 32'd0,         0, 0, 1'b0, mk(32'h248,       4, 1, 0, 1, 32'h248,    0, 0));
        run(I_BREG, 1'b1, 32'h1234_5678, 0, 0, 1'b0, mk(32'h1234_5678, 4, 1, 0, 0, 0,          0, 0));
        run(I_ALU,  1'b0, 32'd0,         2, 0, 1'b0, mk(32'h1234_567C, 6, 1, 1, 0, 0,          0, 0));
        run(I_LD,   1'b0, 32'd0,         0, 3, 1'b1, mk(32'h1234_5680, 8, 1, 1, 0, 0,          4, 0));
        run(I_ST,   1'b0, 32'd0,         0, 0, 1'b1, mk(32'h1234_5684, 4, 1, 0, 0, 0,          1, 1));
        run(I_BREG, 1'b0, 32'hDEAD_0000, 0, 0, 1'b0, mk(32'h1234_5688, 4, 1, 0, 0, 0,          0, 0));
        run(I_BREG, 1'b1, 32'hFFFF_FFFC, 0, 0, 1'b0, mk(32'hFFFF_FFFC, 4, 1, 0, 0, 0,          0, 0));
        run(I_ALU,  1'b0, 32'd0,         0, 0, 1'b0, mk(32'h0,         4, 1, 1, 0, 0,          0, 0));

        wait_state(3'd1, ok);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("pre_rst_imem_req", 32'(imem_req), 32'd1);

        // Asynchronous reset mid-fetch: strobes must fall before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'd0);
        chk("arst_state",    32'(state),    32'd0);
        chk("arst_pc",       pc,            32'd0);
        @(negedge clk);
        rst = 1'b0;

        wait_state(3'd1, ok);
        imem_rdata = I_HALT;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("halt_state", 32'(state),  32'd7);
        chk("halted",     32'(halted), 32'd1);
        chk("halt_ir",    ir,          I_HALT);
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_hold_state", 32'(state),    32'd7);
            chk("halt_imem_req",   32'(imem_req), 32'd0);
            chk("halt_dmem_req",   32'(dmem_req), 32'd0);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("halt_exit_state",  32'(state),  32'd0);
        chk("halt_exit_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer for the KGP-RISC core.
- Owns the PC and instruction register (IR) and steps each instruction through fetch/decode/execute/memory/writeback.
- Uses the combinational branch-condition output (valid_jump) to pick the next PC, and issues the enable strobes for the ALU, register file and data memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that enters HALT.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leaves IDLE; sampled only in IDLE.
- imem_ack  in  1  instruction word valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_ack  in  1  data access complete this cycle.
- valid_jump  in  1  branch condition for the current opcode, from the jump-condition logic.
- rs_value  in  32  register operand; used as the target of register branches.
- pc  out  32  current PC.
- ir  out  32  latched instruction.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- alu_en  out  1  ALU operate strobe.
- reg_we  out  1  register file write strobe.
- link_we  out  1  link register write strobe.
- link_data  out  32  return address (pc+4).
- halted  out  1  sequencer is in HALT.
- state  out  3  FSM state, for debug.

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, BRANCH=4, MEM=5, WB=6, HALT=7.
- Reset (asynchronous, any state, including mid-handshake):
  - state=IDLE, pc=RESET_PC, ir=0.
  - All strobes drop immediately.
- Strobes are pure decodes of state, with no registered delay:
  - imem_req = (state==FETCH).
  - alu_en = (state==EXEC).
  - dmem_req = (state==MEM).
  - dmem_we = (state==MEM and opcode==010001).
  - reg_we = (state==WB).
  - link_we = (state==BRANCH and opcode==001101).
  - halted = (state==HALT).
- link_data = pc+4 at all times.
- Opcode is ir[31:26].
- Opcode classes:
  - Branch: 001000..001111. 001011 is the register branch; 001101 is branch-and-link.
  - Load: 010000.
  - Store: 010001.
  - HALT: HALT_OP.
  - All other opcodes are ALU ops.
- Transitions:
  - IDLE: goes to FETCH when start=1; otherwise stays.
  - FETCH: holds while imem_ack=0. On imem_ack=1, ir<=imem_rdata and go to DECODE.
  - DECODE: 1 cycle. HALT_OP goes to HALT; everything else goes to EXEC.
  - EXEC: 1 cycle. Branch goes to BRANCH, load/store go to MEM, ALU goes to WB.
  - EXEC latches taken=valid_jump and tgt_reg=rs_value at the end of the cycle.
  - BRANCH, not taken: pc<=pc+4.
  - BRANCH, taken, opcode 001011: pc<=tgt_reg.
  - BRANCH, taken, other branch opcodes: pc<=pc+4+(sext(ir[25:0])<<2).
  - BRANCH then goes to FETCH.
  - MEM: holds while dmem_ack=0. On ack, load goes to WB; store does pc<=pc+4 and goes to FETCH.
  - WB: pc<=pc+4, then go to FETCH.
  - HALT: terminal; only rst exits it.
- Arithmetic:
  - All PC arithmetic is 32-bit, modulo 2^32. pc=32'hFFFF_FFFC plus 4 wraps to 0.
  - Negative offsets are sign-extended from bit 25.
- link_we pulses in BRANCH for 001101 whether or not the branch is taken; link_data is the pre-update pc+4.
- start is ignored outside IDLE.
- Acks arriving outside FETCH/MEM are ignored.
- With zero-wait memories, latency is:
  - ALU op: 4 cycles (F,D,E,WB).
  - Branch: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset, start=1, ALU instr (opcode 000000) with imem_ack on first FETCH cycle:
  - State sequence 1,2,3,6,1.
  - alu_en high for exactly 1 cycle, reg_we for 1 cycle.
  - pc goes 0 to 4.
- pc=0x100, opcode 001100 (b), imm=-2, valid_jump=1:
  - pc becomes 0x0FC.
  - The same instruction with valid_jump=0 gives pc=0x104.
- pc=0x200, opcode 001101 (bl), imm=0x10, valid_jump=1:
  - link_we pulses once with link_data=0x204.
  - pc becomes 0x244.
- Opcode 001011 with rs_value=0x1234_5678 and valid_jump=1:
  - pc becomes 0x1234_5678.
- Load with dmem_ack delayed 3 cycles:
  - dmem_req stays high 4 cycles, then WB.
  - Total 8 cycles, pc+=4.
  - Store with dmem_ack immediate: 4 cycles, no reg_we.
- Assert rst during FETCH with imem_req=1:
  - imem_req drops in the same cycle.
  - state=0, pc=RESET_PC.
- Fetch HALT_OP: halted=1; start, imem_ack and dmem_ack are ignored until rst.
